// File: rtl/pipe_pkg.sv
// Shared constants and helpers for elastic pipeline slices.
package pipe_pkg;

    localparam int PIPE_MODE_SIMPLE = 0;
    localparam int PIPE_MODE_SKID   = 1;

    function automatic int occ_width(input int depth, input int skid);
        return $clog2(depth * (skid + 1) + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/ready register stage: skid buffer or single entry.
module elastic_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = PIPE_MODE_SKID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = i_valid && o_ready;
    assign w_out_fire = r_valid && i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    if (SKID == PIPE_MODE_SIMPLE) begin : g_simple
        assign o_ready = !r_valid || i_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (i_flush) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_in_fire) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end
        end
    end else begin : g_skid
        logic             r_skid_valid;
        logic [WIDTH-1:0] r_skid_data;

        // ready comes straight from a flop, breaking the ready chain
        assign o_ready = !r_skid_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid      <= 1'b0;
                r_data       <= '0;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
            end else if (i_flush) begin
                r_valid      <= 1'b0;
                r_data       <= '0;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
            end else if (w_out_fire || !r_valid) begin
                if (r_skid_valid) begin
                    r_valid      <= 1'b1;
                    r_data       <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                end else if (w_in_fire) begin
                    r_valid <= 1'b1;
                    r_data  <= i_data;
                end else begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH chained elastic stages with flush and an occupancy counter.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int SKID  = PIPE_MODE_SKID
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    out_data,
    input  logic                                out_ready,
    output logic [occ_width(DEPTH, SKID)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH, SKID);

    logic             w_in_fire;
    logic             w_out_fire;
    logic [OCC_W-1:0] r_occ;

    for (genvar k = 0; k < DEPTH; k++) begin : g_st
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;
        logic             w_up_ready;
        logic             w_dn_ready;
        logic             w_vld;
        logic [WIDTH-1:0] w_dat;

        if (k == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_link
            assign w_up_valid = g_st[k-1].w_vld;
            assign w_up_data  = g_st[k-1].w_dat;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_next
            assign w_dn_ready = g_st[k+1].w_up_ready;
        end

        elastic_stage #(
            .WIDTH (WIDTH),
            .SKID  (SKID)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush),
            .i_valid (w_up_valid),
            .i_data  (w_up_data),
            .o_ready (w_up_ready),
            .o_valid (w_vld),
            .o_data  (w_dat),
            .i_ready (w_dn_ready)
        );
    end

    assign in_ready   = g_st[0].w_up_ready;
    assign out_valid  = g_st[DEPTH-1].w_vld;
    assign out_data   = g_st[DEPTH-1].w_dat;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign occupancy  = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

endmodule
